// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter, one shamt bit per cycle MSB first, valid/ready on both sides.
// Define ITER_SHIFTER_ROTATE_EN to make op=11 a rotate-left; otherwise op=11 behaves as SLL.
module iterative_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [1:0]         i_op,
    input  logic [WIDTH-1:0]   i_data_in,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WIDTH-1:0]   o_data_out,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_op;
    logic [SHAMT_W-1:0] r_shamt;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic               r_msb;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               w_bit;
    logic [WIDTH-1:0]   w_acc_nxt;

    // One stage: shift by 2^k; SRA fill comes from the MSB captured at accept.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0]   acc,
        input logic [1:0]         op,
        input logic [SHAMT_W-1:0] k,
        input logic               msb
    );
        logic [WIDTH-1:0] res;
        int unsigned      amt;
        amt = 32'd1 << k;
        case (op)
            2'b00:   res = acc << amt;
            2'b01:   res = acc >> amt;
            2'b10:   res = (acc >> amt) | (msb ? ~({WIDTH{1'b1}} >> amt) : {WIDTH{1'b0}});
`ifdef ITER_SHIFTER_ROTATE_EN
            2'b11:   res = (acc << amt) | (acc >> (WIDTH - amt));
`else
            2'b11:   res = acc << amt;
`endif
            default: res = acc << amt;
        endcase
        return res;
    endfunction

    // Stage datapath for the current counter position.
    always_comb begin
        w_bit     = |(r_shamt & (SHAMT_W'(1) << r_cnt));
        w_acc_nxt = r_acc;
        if (w_bit) begin
            w_acc_nxt = stage_shift(r_acc, r_op, r_cnt, r_msb);
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_state_nxt = (i_shamt == {SHAMT_W{1'b0}}) ? S_DONE : S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == {SHAMT_W{1'b0}}) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_op       <= 2'b00;
            r_shamt    <= {SHAMT_W{1'b0}};
            r_cnt      <= {SHAMT_W{1'b0}};
            r_acc      <= {WIDTH{1'b0}};
            r_msb      <= 1'b0;
            r_data_out <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_op    <= i_op;
                        r_shamt <= i_shamt;
                        r_cnt   <= SHAMT_W'(SHAMT_W - 1);
                        r_acc   <= i_data_in;
                        r_msb   <= i_data_in[WIDTH-1];
                        if (i_shamt == {SHAMT_W{1'b0}}) begin
                            r_data_out <= i_data_in;
                        end else begin
                            r_data_out <= r_data_out;
                        end
                    end else begin
                        r_acc <= r_acc;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_nxt;
                    if (r_cnt == {SHAMT_W{1'b0}}) begin
                        r_data_out <= w_acc_nxt;
                    end else begin
                        r_cnt <= r_cnt - SHAMT_W'(1);
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_data_out  = r_data_out;

endmodule
